// File: rtl/ext_mux_unit.sv
// Write-back glue for the single-cycle MIPS core: immediate extender, destination-register
// and write-data selectors, plus the write-back register stage. Define EXT_MUX_LUI_EN to enable LUI placement.
module ext_mux_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imm16,
  input  logic [1:0]  ext_op,
  output logic [31:0] ext_out,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [1:0]  reg_dst,
  input  logic [31:0] alu_result,
  input  logic [31:0] dm_data,
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  mem_to_reg,
  input  logic        reg_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_we
);

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;
  localparam logic [1:0] EXT_BOFF  = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;
  localparam logic [1:0] DST_R0  = 2'b11;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  logic [4:0]  wb_reg_d,  wb_reg_q;
  logic [31:0] wb_data_d, wb_data_q;
  logic        wb_we_d,   wb_we_q;

  // Immediate extension; the LUI code falls back to zero-extend when the feature is off.
  always_comb begin
    ext_out = 32'h0000_0000;
    case (ext_op)
      EXT_ZERO:  ext_out = {16'h0000, imm16};
      EXT_SIGN:  ext_out = {{16{imm16[15]}}, imm16};
`ifdef EXT_MUX_LUI_EN
      EXT_UPPER: ext_out = {imm16, 16'h0000};
`else
      EXT_UPPER: ext_out = {16'h0000, imm16};
`endif
      EXT_BOFF:  ext_out = {{14{imm16[15]}}, imm16, 2'b00};
      default:   ext_out = 32'h0000_0000;
    endcase
  end

  // Destination register select.
  always_comb begin
    wb_reg_d = 5'd0;
    case (reg_dst)
      DST_RT:  wb_reg_d = rt;
      DST_RD:  wb_reg_d = rd;
      DST_R31: wb_reg_d = 5'd31;
      DST_R0:  wb_reg_d = 5'd0;
      default: wb_reg_d = 5'd0;
    endcase
  end

  // Write-back data select.
  always_comb begin
    wb_data_d = 32'h0000_0000;
    case (mem_to_reg)
      SRC_ALU:  wb_data_d = alu_result;
      SRC_MEM:  wb_data_d = dm_data;
      SRC_LINK: wb_data_d = pc_plus4;
      SRC_ZERO: wb_data_d = 32'h0000_0000;
      default:  wb_data_d = 32'h0000_0000;
    endcase
  end

  // r0 is hardwired, so writes targeting it are dropped while address/data still flow.
  always_comb begin
    wb_we_d = 1'b0;
    if (wb_reg_d != 5'd0) begin
      wb_we_d = reg_write;
    end else begin
      wb_we_d = 1'b0;
    end
  end

  // Write-back register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_q  <= 5'd0;
      wb_data_q <= 32'h0000_0000;
      wb_we_q   <= 1'b0;
    end else begin
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
    end
  end

  assign wb_reg  = wb_reg_q;
  assign wb_data = wb_data_q;
  assign wb_we   = wb_we_q;

endmodule

// File: tb/tb_ext_mux_unit.sv
// Directed self-checking bench for ext_mux_unit; expectations follow EXT_MUX_LUI_EN.
module tb_ext_mux_unit;

  logic        clk;
  logic        reset;
  logic [15:0] imm16;
  logic [1:0]  ext_op;
  logic [31:0] ext_out;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  reg_dst;
  logic [31:0] alu_result;
  logic [31:0] dm_data;
  logic [31:0] pc_plus4;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_we;

  int checks_total;
  int checks_passed;

  ext_mux_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imm16      (imm16),
    .ext_op     (ext_op),
    .ext_out    (ext_out),
    .rt         (rt),
    .rd         (rd),
    .reg_dst    (reg_dst),
    .alu_result (alu_result),
    .dm_data    (dm_data),
    .pc_plus4   (pc_plus4),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .wb_we      (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total = checks_total + 1;
    if (obs === exp) begin
      checks_passed = checks_passed + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] er, input logic [31:0] ed, input logic ew);
    check_val({tag, "_reg"}, {27'd0, wb_reg}, {27'd0, er});
    check_val({tag, "_data"}, wb_data, ed);
    check_val({tag, "_we"}, {31'd0, wb_we}, {31'd0, ew});
  endtask

  initial begin
    logic [31:0] exp_lui;
    checks_total  = 0;
    checks_passed = 0;
`ifdef EXT_MUX_LUI_EN
    exp_lui = 32'h8001_0000;
`else
    exp_lui = 32'h0000_8001;
`endif

    // Reset held with arbitrary inputs that would otherwise write.
    reset      = 1'b0;
    imm16      = 16'h8001;
    ext_op     = 2'b01;
    rt         = 5'd7;
    rd         = 5'd12;
    reg_dst    = 2'b01;
    alu_result = 32'hA5A5_5A5A;
    dm_data    = 32'h1111_2222;
    pc_plus4   = 32'h0000_0040;
    mem_to_reg = 2'b00;
    reg_write  = 1'b1;
    repeat (3) after_edge();
    check_wb("rst", 5'd0, 32'h0, 1'b0);
    check_val("ext_in_reset", ext_out, 32'hFFFF_8001);

    // First capture after release.
    @(negedge clk);
    reset      = 1'b1;
    rd         = 5'd9;
    reg_dst    = 2'b01;
    alu_result = 32'h1234_5678;
    mem_to_reg = 2'b00;
    reg_write  = 1'b1;
    after_edge();
    check_wb("first", 5'd9, 32'h1234_5678, 1'b1);

    // Inputs changed mid-cycle must not reach the outputs before the next edge.
    alu_result = 32'hCAFE_F00D;
    rd         = 5'd3;
    #2;
    check_wb("hold", 5'd9, 32'h1234_5678, 1'b1);

    // Extension sweep.
    imm16 = 16'h8001;
    ext_op = 2'b00; #1; check_val("ext_zero", ext_out, 32'h0000_8001);
    ext_op = 2'b01; #1; check_val("ext_sign", ext_out, 32'hFFFF_8001);
    ext_op = 2'b10; #1; check_val("ext_upper", ext_out, exp_lui);
    ext_op = 2'b11; #1; check_val("ext_boff", ext_out, 32'hFFFE_0004);
    imm16 = 16'h7FFF;
    ext_op = 2'b01; #1; check_val("ext_sign_pos", ext_out, 32'h0000_7FFF);
    ext_op = 2'b11; #1; check_val("ext_boff_pos", ext_out, 32'h0001_FFFC);

    // Link write-back.
    after_edge();
    reg_dst    = 2'b10;
    mem_to_reg = 2'b10;
    pc_plus4   = 32'h0000_3008;
    reg_write  = 1'b1;
    after_edge();
    check_wb("link", 5'd31, 32'h0000_3008, 1'b1);

    // r0 write suppression.
    rt         = 5'd0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b01;
    dm_data    = 32'hDEAD_BEEF;
    reg_write  = 1'b1;
    after_edge();
    check_wb("r0", 5'd0, 32'hDEAD_BEEF, 1'b0);

    // reg_write low with a non-zero destination.
    rt         = 5'd17;
    reg_write  = 1'b0;
    after_edge();
    check_wb("nowr", 5'd17, 32'hDEAD_BEEF, 1'b0);

    // Undefined-looking codes decode to r0 / zero.
    reg_dst    = 2'b11;
    mem_to_reg = 2'b11;
    reg_write  = 1'b1;
    after_edge();
    check_wb("code11", 5'd0, 32'h0, 1'b0);
    check_val("no_x", {31'd0, $isunknown({wb_reg, wb_data, wb_we, ext_out})}, 32'd0);

    // Asynchronous reset between edges.
    reg_dst    = 2'b01;
    rd         = 5'd21;
    mem_to_reg = 2'b00;
    alu_result = 32'h0BAD_F00D;
    reg_write  = 1'b1;
    after_edge();
    check_wb("pre_async", 5'd21, 32'h0BAD_F00D, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_wb("async", 5'd0, 32'h0, 1'b0);
    after_edge();
    check_wb("rst_edge", 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    after_edge();
    check_wb("post_rst", 5'd21, 32'h0BAD_F00D, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
